// File: rtl/pipeline_types.sv
// rtl/pipeline_types.sv - instruction entry type shared by fetch, instruction queue and id
package pipeline_types;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        is_exception;
      logic [6:0]  exception_cause;
      logic        pre_is_branch;
      logic        pre_taken;
      logic [31:0] pre_branch_addr;
   } inst_entry_t;

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - two-in/one-out decoupling instruction queue between fetch and id
module inst_queue
   import pipeline_types::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       pause,
   input  logic [1:0]                 in_valid,
   input  inst_entry_t                in_entry0,
   input  inst_entry_t                in_entry1,
   output logic                       in_ready,
   output logic                       out_valid,
   output inst_entry_t                out_entry,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   inst_entry_t             mem_q [DEPTH];
   inst_entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        wr_ptr_p1;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [CNT_W-1:0]        enq_n;
   logic                    deq;

   // Ready looks only at registered occupancy so pause never reaches fetch combinationally.
   assign in_ready  = (count_q <= CNT_W'(DEPTH - 2));
   assign out_valid = (count_q != '0);
   assign out_entry = out_valid ? mem_q[rd_ptr_q] : '0;
   assign count     = count_q;
   assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

   always_comb begin
      enq_n = '0;
      if (in_ready && !flush) begin
         case (in_valid)
            2'b01:   enq_n = CNT_W'(1);
            2'b11:   enq_n = CNT_W'(2);
            default: enq_n = '0;
         endcase
      end
      deq = out_valid && !pause && !flush;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(deq);
         wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
         count_d  = count_q + enq_n - CNT_W'(deq);
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (enq_n != '0) begin
         mem_d[wr_ptr_q] = in_entry0;
      end
      if (enq_n == CNT_W'(2)) begin
         mem_d[wr_ptr_p1] = in_entry1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - table-driven scoreboard bench for inst_queue
module tb_inst_queue;
   import pipeline_types::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        pause;
   logic [1:0]  in_valid;
   inst_entry_t in_entry0;
   inst_entry_t in_entry1;
   logic        in_ready;
   logic        out_valid;
   inst_entry_t out_entry;
   logic [3:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   inst_entry_t sb[$];

   typedef struct {
      logic        flush;
      logic        pause;
      logic [1:0]  iv;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic        exc;
      logic [6:0]  cause;
      int          exp_count;
      logic        exp_ready;
   } vec_t;

   vec_t vt[$];

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .pause     (pause),
      .in_valid  (in_valid),
      .in_entry0 (in_entry0),
      .in_entry1 (in_entry1),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_entry (out_entry),
      .count     (count)
   );

   always #5 clk = ~clk;

   function automatic inst_entry_t mk(input logic [31:0] pc, input logic exc, input logic [6:0] cause);
      inst_entry_t e;
      e.pc              = pc;
      e.inst            = pc ^ 32'h1357_9bdf;
      e.is_exception    = exc;
      e.exception_cause = cause;
      e.pre_is_branch   = pc[2];
      e.pre_taken       = pc[3];
      e.pre_branch_addr = pc + 32'h40;
      return e;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_e(input string name, input inst_entry_t act, input inst_entry_t exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got pc=%h exc=%b cause=%h (%h) expected pc=%h exc=%b cause=%h (%h)",
                  name, act.pc, act.is_exception, act.exception_cause, act,
                  exp.pc, exp.is_exception, exp.exception_cause, exp);
      end
   endtask

   task automatic add(input logic f, input logic p, input logic [1:0] iv, input logic [31:0] pc0,
                      input logic [31:0] pc1, input logic exc, input logic [6:0] cause,
                      input int cnt, input logic rdy);
      vec_t r;
      r.flush = f; r.pause = p; r.iv = iv; r.pc0 = pc0; r.pc1 = pc1;
      r.exc = exc; r.cause = cause; r.exp_count = cnt; r.exp_ready = rdy;
      vt.push_back(r);
   endtask

   task automatic apply(input vec_t r, input int idx);
      inst_entry_t exp_e;
      bit          accept;
      @(negedge clk);
      flush     = r.flush;
      pause     = r.pause;
      in_valid  = r.iv;
      in_entry0 = mk(r.pc0, r.exc, r.cause);
      in_entry1 = mk(r.pc1, 1'b0, 7'd0);
      #1;
      chk($sformatf("count[%0d]", idx), count, r.exp_count);
      chk($sformatf("in_ready[%0d]", idx), in_ready, r.exp_ready);
      chk($sformatf("out_valid[%0d]", idx), out_valid, sb.size() != 0);
      exp_e = (sb.size() != 0) ? sb[0] : '0;
      chk_e($sformatf("out_entry[%0d]", idx), out_entry, exp_e);
      accept = (sb.size() <= DEPTH - 2) && !r.flush;
      if (r.flush) begin
         sb.delete();
      end else begin
         if (sb.size() != 0 && !r.pause) void'(sb.pop_front());
         if (accept && (r.iv == 2'b01 || r.iv == 2'b11)) sb.push_back(in_entry0);
         if (accept && r.iv == 2'b11) sb.push_back(in_entry1);
      end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; pause = 1'b0; in_valid = 2'b00;
      in_entry0 = '0; in_entry1 = '0;
      #1;
      chk("reset count", count, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset in_ready", in_ready, 1);
      chk_e("reset out_entry", out_entry, '0);
      @(negedge clk);
      rst = 1'b1;

      //   f  p  iv     pc0            pc1           exc  cause  cnt rdy
      add(0, 1, 2'b00, 32'h0,         32'h0,         0, 7'h00, 0, 1);
      add(0, 0, 2'b11, 32'h1c000000,  32'h1c000004,  0, 7'h00, 0, 1);
      add(0, 0, 2'b11, 32'h1c000008,  32'h1c00000c,  0, 7'h00, 2, 1);
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 3, 1);
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 2, 1);
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 1, 1);
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 0, 1);
      add(0, 1, 2'b11, 32'h100,       32'h104,       0, 7'h00, 0, 1);
      add(0, 1, 2'b11, 32'h108,       32'h10c,       0, 7'h00, 2, 1);
      add(0, 1, 2'b11, 32'h110,       32'h114,       0, 7'h00, 4, 1);
      add(0, 1, 2'b00, 32'h0,         32'h0,         0, 7'h00, 6, 1);
      add(0, 1, 2'b11, 32'h118,       32'h11c,       0, 7'h00, 6, 1);
      add(0, 1, 2'b11, 32'h120,       32'h124,       0, 7'h00, 8, 0);
      add(0, 1, 2'b01, 32'h128,       32'h12c,       0, 7'h00, 8, 0);
      add(0, 0, 2'b11, 32'h130,       32'h134,       0, 7'h00, 8, 0);
      add(0, 0, 2'b11, 32'h138,       32'h13c,       0, 7'h00, 7, 0);
      add(1, 1, 2'b11, 32'h140,       32'h144,       0, 7'h00, 6, 1);
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 0, 1);
      for (int i = 0; i < 7; i++) begin
         add(0, 0, 2'b01, 32'h200 + 32'(4 * i), 32'h0, 0, 7'h00, (i == 0) ? 0 : 1, 1);
      end
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 1, 1);
      add(0, 0, 2'b11, 32'h300,       32'h304,       0, 7'h00, 0, 1);
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 2, 1);
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 1, 1);
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 0, 1);
      add(0, 0, 2'b10, 32'h400,       32'h404,       0, 7'h00, 0, 1);
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 0, 1);
      add(0, 0, 2'b01, 32'h500,       32'h504,       1, 7'h08, 0, 1);
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 1, 1);
      add(0, 0, 2'b00, 32'h0,         32'h0,         0, 7'h00, 0, 1);

      for (int i = 0; i < vt.size(); i++) begin
         apply(vt[i], i);
      end

      // Hand sequence: asynchronous reset in the middle of a cycle.
      vt.delete();
      add(0, 0, 2'b11, 32'h600, 32'h604, 0, 7'h00, 0, 1);
      add(0, 1, 2'b00, 32'h0,   32'h0,   0, 7'h00, 2, 1);
      apply(vt[0], 100);
      apply(vt[1], 101);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("async reset count", count, 0);
      chk("async reset out_valid", out_valid, 0);
      chk_e("async reset out_entry", out_entry, '0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      vt.delete();
      add(0, 0, 2'b00, 32'h0, 32'h0, 0, 7'h00, 0, 1);
      apply(vt[0], 102);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
# inst_queue

Decoupling instruction queue between frontend fetch and backend decode. It accepts up to two fetched instructions per cycle with their PC, exception tag and branch-prediction info. It presents them in program order, one per cycle, to the `id` stage. It also absorbs backend pauses and discards all contents on a pipeline flush, whether from a branch mispredict or an exception.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥ 4.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all entries (branch_flush OR exception_flush).
- `pause`  in  1  backend decode stalled; hold the head entry.
- `in_valid`  in  2  bit0 = slot 0 valid, bit1 = slot 1 valid.
- `in_entry0`  in  `inst_entry_t`  slot 0 instruction (older).
- `in_entry1`  in  `inst_entry_t`  slot 1 instruction (younger).
- `in_ready`  out  1  queue can accept two entries this cycle.
- `out_valid`  out  1  head entry valid.
- `out_entry`  out  `inst_entry_t`  head entry; all-zero when `out_valid`=0.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- `inst_entry_t` fields:
  - `pc` [31:0], `inst` [31:0].
  - `is_exception` 1, `exception_cause` [6:0].
  - `pre_is_branch` 1, `pre_taken` 1, `pre_branch_addr` [31:0].
- Storage: flop array of `DEPTH` entries, head pointer `rd_ptr`, tail pointer `wr_ptr`, occupancy counter `count`. Pointers wrap modulo `DEPTH`.
- Enqueue happens when `in_ready` is 1 and `flush` is 0:
  - `in_valid`=01 writes slot 0 at `wr_ptr`; `wr_ptr` advances by 1.
  - `in_valid`=11 writes slot 0 at `wr_ptr` and slot 1 at `wr_ptr+1`; `wr_ptr` advances by 2.
  - `in_valid`=10 is non-contiguous; enqueues nothing and advances nothing.
- Dequeue happens when `out_valid` is 1, `pause` is 0 and `flush` is 0. `rd_ptr` advances by 1.
- `count_next` = `count` + enqueued − dequeued (range 0..DEPTH). Enqueue and dequeue in the same cycle are legal.
- `in_ready` = (`count` ≤ DEPTH−2), taken from the registered `count` only. It does not depend on the same-cycle dequeue, and there is no combinational path from `pause` to `in_ready`.
- `out_valid` = (`count` ≠ 0). `out_entry` = `array[rd_ptr]` when valid, else 0.
- Flush: on the next edge `count`, `rd_ptr` and `wr_ptr` all become 0. Same-cycle enqueue and dequeue are suppressed. Flush has priority over `pause` and `in_valid`.
- Overflow is impossible by construction. If `in_valid` is nonzero while `in_ready`=0, the input is ignored; the frontend must hold it.

## Timing
- Reset (`rst`=0, asynchronous): pointers = 0, `count` = 0, `out_valid` = 0, `out_entry` = 0. Array contents need not be reset.
- Enqueue-to-output latency is 1 cycle; there is no bypass. An entry written at edge N appears on `out_entry` after edge N.
- Throughput: 2 entries/cycle in, 1 entry/cycle out.
- Full boundary: at `count`=DEPTH−1 or DEPTH, `in_ready` is 0, even if a dequeue is happening.
- Empty boundary: at `count`=0, `pause` has no effect and `out_valid` stays 0.
- Wrap: a two-entry enqueue at `wr_ptr`=DEPTH−1 writes index DEPTH−1 and index 0.
- Reset asserted mid-operation clears the queue immediately, without waiting for a clock edge.

## Structure
- `inst_entry_t` goes in `pipeline_types` so that fetch and `id` share it.
- `DEPTH` stays local to this block.
- No sub-module. The pointer/count logic and the flop array stay in one module of about 150 lines.
- Top-level integration: `out_entry` drives the `id` input fields; `pause` = `pause_id` OR `pause_dispatch`.

## Test plan
- Reset then idle: `out_valid`=0, `count`=0, `in_ready`=1, `out_entry`=0.
- Enqueue pairs with pc 0x1c000000/04, then 08/0c; `pause`=0 → `out_entry.pc` is 00, 04, 08, 0c on consecutive cycles, and `count` ends at 0.
- Pause held while enqueuing pairs with DEPTH=8 → after 3 pairs `count`=6 and `in_ready`=1. After the 4th pair `count`=8 and `in_ready`=0; further inputs are ignored and the head pc is unchanged.
- Fill to 6, then assert `flush` together with `in_valid`=11 → next cycle `count`=0 and `out_valid`=0. The flushed-cycle input is not stored.
- Wrap case: `rd_ptr`=`wr_ptr`=7, enqueue pair A/B → A is read from index 7 and B from index 0, in order.
- `in_valid`=10 and an exception-tagged entry: the 10 input enqueues nothing. An entry with `is_exception`=1 and `exception_cause`=0x08 emerges with those fields intact.
